// File: rtl/mult_pkg.sv
// Shared types for the shift-add multiplier: FSM state encoding and width limits.
package mult_pkg;

  typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, DONE} mult_state_t;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/reg_n.sv
// N-bit register with synchronous reset, parallel load and right shift.
// Load has priority over shift; Shift_Out exposes the bit leaving on the next shift.
module reg_n #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Shift_En,
  input  logic             Shift_In,
  input  logic [WIDTH-1:0] D,
  output logic             Shift_Out,
  output logic [WIDTH-1:0] Data_Out
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge Clk) begin
    if (Reset)
      Data_Out <= '0;
    else if (Load)
      Data_Out <= D;
    else if (Shift_En)
      Data_Out <= {Shift_In, Data_Out[WIDTH-1:1]};
  end

  assign Shift_Out = Data_Out[0];

endmodule

// File: rtl/shift_add_mult_unit.sv
// Sequential shift-add multiplier: A accumulates, B holds the multiplier and
// becomes the low product half; X carries the sign (signed) or carry (unsigned).
module shift_add_mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Ld_B,
  input  logic               Start,
  input  logic [WIDTH-1:0]   S,
  output logic               Busy,
  output logic               Done,
  output logic               X,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Product
);

  localparam int CW = $clog2(WIDTH + 1);

  mult_state_t    state;
  logic [CW-1:0]  count;
  logic           x_q;
  logic           busy_q;
  logic           done_q;

  logic [WIDTH-1:0] a_q, b_q, a_d;
  logic             a_load, a_shift, b_load, b_shift;
  logic             a_lsb, b_lsb;
  logic [WIDTH:0]   ext_a, ext_s, sum;
  logic             last_step;

  assign last_step = (count == CW'(WIDTH - 1));

  // The final multiplier bit of a two's-complement operand has negative weight,
  // so its partial product is subtracted instead of added.
  always_comb begin
    ext_a = SIGNED ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
    ext_s = SIGNED ? {S[WIDTH-1], S}     : {1'b0, S};
    if (SIGNED && last_step)
      sum = ext_a - ext_s;
    else
      sum = ext_a + ext_s;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    a_load  = 1'b0;
    a_shift = 1'b0;
    b_load  = 1'b0;
    b_shift = 1'b0;
    a_d     = sum[WIDTH-1:0];
    unique case (state)
      IDLE: if (Ld_B) begin
        a_load = 1'b1;
        a_d    = '0;
        b_load = 1'b1;
      end
      CLR: begin
        a_load = 1'b1;
        a_d    = '0;
      end
      ADD:   a_load = b_lsb;
      SHIFT: begin
        a_shift = 1'b1;
        b_shift = 1'b1;
      end
      default: ;
    endcase
  end

  reg_n #(.WIDTH(WIDTH)) u_reg_a (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (a_load),
    .Shift_En  (a_shift),
    .Shift_In  (x_q),
    .D         (a_d),
    .Shift_Out (a_lsb),
    .Data_Out  (a_q)
  );

  reg_n #(.WIDTH(WIDTH)) u_reg_b (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (b_load),
    .Shift_En  (b_shift),
    .Shift_In  (a_lsb),
    .D         (S),
    .Shift_Out (b_lsb),
    .Data_Out  (b_q)
  );

  // Busy/Done are registered alongside the state so they never glitch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      count  <= '0;
      x_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Ld_B)
            x_q <= 1'b0;
          else if (Start) begin
            state  <= CLR;
            busy_q <= 1'b1;
          end
        end
        CLR: begin
          x_q   <= 1'b0;
          count <= '0;
          state <= ADD;
        end
        ADD: begin
          x_q   <= b_lsb ? sum[WIDTH] : (SIGNED & a_q[WIDTH-1]);
          state <= SHIFT;
        end
        SHIFT: begin
          if (!SIGNED)
            x_q <= 1'b0;
          count <= count + CW'(1);
          if (last_step) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state <= ADD;
          end
        end
        DONE: begin
          // Leaving only on Start low keeps a held Start from re-triggering.
          if (!Start) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign X       = x_q;
  assign A       = a_q;
  assign B       = b_q;
  assign Product = {a_q, b_q};

endmodule

// File: tb/tb_shift_add_mult_unit.sv
// Directed bench: signed and unsigned 8-bit units share stimulus; a signed
// 16-bit unit covers the wide case.
module tb_shift_add_mult_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_b8, start8;
  logic [7:0]  s8;
  logic        ld_b16, start16;
  logic [15:0] s16;

  logic        busy_s8, done_s8, x_s8;
  logic [7:0]  a_s8, b_s8;
  logic [15:0] p_s8;
  logic        busy_u8, done_u8, x_u8;
  logic [7:0]  a_u8, b_u8;
  logic [15:0] p_u8;
  logic        busy_16, done_16, x_16;
  logic [15:0] a_16, b_16;
  logic [31:0] p_16;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_add_mult_unit #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .Clk(clk), .Reset(reset), .Ld_B(ld_b8), .Start(start8), .S(s8),
    .Busy(busy_s8), .Done(done_s8), .X(x_s8), .A(a_s8), .B(b_s8), .Product(p_s8)
  );

  shift_add_mult_unit #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .Clk(clk), .Reset(reset), .Ld_B(ld_b8), .Start(start8), .S(s8),
    .Busy(busy_u8), .Done(done_u8), .X(x_u8), .A(a_u8), .B(b_u8), .Product(p_u8)
  );

  shift_add_mult_unit #(.WIDTH(16), .SIGNED(1'b1)) u_s16 (
    .Clk(clk), .Reset(reset), .Ld_B(ld_b16), .Start(start16), .S(s16),
    .Busy(busy_16), .Done(done_16), .X(x_16), .A(a_16), .B(b_16), .Product(p_16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit multiply on both units. combined: Start raised with Ld_B.
  // ld_busy: pulse Ld_B mid-operation. hold: extra DONE cycles with Start high.
  task automatic run8(input string name, input logic [7:0] b, input logic [7:0] s,
                      input logic [15:0] exp_s, input logic [15:0] exp_u,
                      input bit combined, input bit ld_busy, input int hold);
    int n;
    ld_b8  = 1'b1;
    s8     = b;
    start8 = combined;
    tick();
    if (combined) begin
      check({name, "_ldwins_busy"}, busy_s8, 1'b0);
      check({name, "_ldwins_b"}, b_s8, b);
    end
    ld_b8  = 1'b0;
    s8     = s;
    start8 = 1'b1;
    tick();
    n = 1;
    check({name, "_busy"}, busy_u8, 1'b1);
    while (!done_s8 && n < 60) begin
      ld_b8 = (ld_busy && n == 4);
      tick();
      n++;
    end
    ld_b8 = 1'b0;
    check({name, "_latency"}, n, 18);
    check({name, "_prod_s"}, p_s8, exp_s);
    check({name, "_prod_u"}, p_u8, exp_u);
    check({name, "_x_u"}, x_u8, 1'b0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({name, "_hold_done"}, done_s8, 1'b1);
      check({name, "_hold_busy"}, busy_s8, 1'b0);
      check({name, "_hold_prod"}, p_s8, exp_s);
    end
    start8 = 1'b0;
    tick();
    check({name, "_done_clr"}, done_s8, 1'b0);
    tick();
    check({name, "_idle_busy"}, busy_s8, 1'b0);
  endtask

  initial begin
    int n;
    reset = 1'b1; ld_b8 = 1'b0; start8 = 1'b0; s8 = '0;
    ld_b16 = 1'b0; start16 = 1'b0; s16 = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_prod_s8", p_s8, 16'h0000);
    check("rst_x_s8", x_s8, 1'b0);
    check("rst_busy_s8", busy_s8, 1'b0);
    check("rst_done_s8", done_s8, 1'b0);
    check("rst_prod_16", p_16, 32'h0);

    // -3 * 7 signed; 253 * 7 unsigned
    run8("t1", 8'hFD, 8'h07, 16'hFFEB, 16'h06EB, 1'b0, 1'b0, 0);
    // -128 * -128 exercises the final-step subtract
    run8("t2", 8'h80, 8'h80, 16'h4000, 16'h4000, 1'b0, 1'b0, 0);
    // 255 * 255 unsigned; -1 * -1 signed
    run8("t3", 8'hFF, 8'hFF, 16'h0001, 16'hFE01, 1'b0, 1'b0, 0);
    // Ld_B+Start together, Ld_B pulsed while busy, Start held in DONE
    run8("t5", 8'hFD, 8'h07, 16'hFFEB, 16'h06EB, 1'b1, 1'b1, 3);

    // Reset during the 5th SHIFT (state SHIFT after sampling edge + 10 edges)
    ld_b8 = 1'b1; s8 = 8'hFD;
    tick();
    ld_b8 = 1'b0; s8 = 8'h07; start8 = 1'b1;
    tick();
    repeat (10) tick();
    check("t4_busy_pre", busy_s8, 1'b1);
    reset = 1'b1; start8 = 1'b0;
    tick();
    check("t4_a", a_s8, 8'h00);
    check("t4_b", b_s8, 8'h00);
    check("t4_x", x_s8, 1'b0);
    check("t4_busy", busy_s8, 1'b0);
    check("t4_done", done_s8, 1'b0);
    check("t4_prod_u", p_u8, 16'h0000);
    reset = 1'b0;
    tick();
    check("t4_idle_busy", busy_s8, 1'b0);
    check("t4_idle_done", done_s8, 1'b0);

    // 16-bit signed: -32768 * 32767
    ld_b16 = 1'b1; s16 = 16'h8000;
    tick();
    ld_b16 = 1'b0; s16 = 16'h7FFF; start16 = 1'b1;
    tick();
    n = 1;
    check("t6_busy", busy_16, 1'b1);
    while (!done_16 && n < 100) begin
      tick();
      n++;
    end
    check("t6_latency", n, 34);
    check("t6_prod", p_16, 32'hC0008000);
    start16 = 1'b0;
    tick();
    check("t6_done_clr", done_16, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
